// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud clock generator: select encoding,
// default counter width and the rounded divisor helpers.
package uart_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_sel_e;

  // Baud rate for a select code; unused codes fall back to 9600.
  function automatic int unsigned baud_of(input logic [2:0] sel);
    case (sel)
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      BAUD_115200: return 115200;
      default:     return 9600;
    endcase
  endfunction

  // Integer division rounded to nearest.
  function automatic int unsigned round_div(input int unsigned num, input int unsigned den);
    return (num + den / 2) / den;
  endfunction

  // Clock cycles per half bit period.
  function automatic int unsigned half_div(input int unsigned clk_freq, input int unsigned baud);
    return round_div(clk_freq, 2 * baud);
  endfunction

  // Clock cycles per oversample tick.
  function automatic int unsigned os_div(input int unsigned clk_freq, input int unsigned oversample,
                                         input int unsigned baud);
    return round_div(clk_freq, oversample * baud);
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Wrap counter with a runtime terminal value, synchronous clear and a
// combinational wrap flag that is high in the cycle the count sits at term.
module clk_div_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Wrap detection uses >= so a terminal that shrinks under the count
  // can never strand it in a long run-out.
  always_comb begin
    wrap     = 1'b0;
    cnt_next = cnt_reg + CNT_W'(1);
    if (clr) begin
      cnt_next = '0;
    end else if (cnt_reg >= term) begin
      wrap     = 1'b1;
      cnt_next = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_clk_gen.sv
// Baud-rate generator: 50 % duty bit clock, bit-rate strobe aligned with the
// rising bit clock, and an independent oversampling strobe for the receiver.
module uart_clk_gen #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = uart_pkg::CNT_W
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic [2:0] baud_sel,
  output logic       clk_out,
  output logic       baud_tick,
  output logic       os_tick
);

  import uart_pkg::*;

  logic [CNT_W-1:0] half_term [8];
  logic [CNT_W-1:0] os_term   [8];
  logic [2:0]       sel_q_reg;
  logic             sel_change;
  logic             bit_wrap;
  logic             os_wrap;
  logic             clk_out_reg;
  logic             baud_tick_reg;
  logic             os_tick_reg;

  // Terminal counts (divisor - 1) for every select code, fixed at elaboration.
  for (genvar gi = 0; gi < 8; gi++) begin : g_div_tbl
    localparam int unsigned HALF  = half_div(CLK_FREQ, baud_of(3'(gi)));
    localparam int unsigned OSDIV = os_div(CLK_FREQ, OVERSAMPLE, baud_of(3'(gi)));
    assign half_term[gi] = CNT_W'(HALF - 1);
    assign os_term[gi]   = CNT_W'(OSDIV - 1);
  end

  // A new select restarts both dividers as if from reset.
  assign sel_change = (sel_q_reg != baud_sel);

  clk_div_cnt #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .clr   (sel_change),
    .term  (half_term[sel_q_reg]),
    .wrap  (bit_wrap)
  );

  clk_div_cnt #(.CNT_W(CNT_W)) u_os_cnt (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .clr   (sel_change),
    .term  (os_term[sel_q_reg]),
    .wrap  (os_wrap)
  );

  // Select register, bit-clock toggle flop and registered strobes.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sel_q_reg     <= '0;
      clk_out_reg   <= 1'b0;
      baud_tick_reg <= 1'b0;
      os_tick_reg   <= 1'b0;
    end else begin
      sel_q_reg <= baud_sel;
      if (sel_change) begin
        clk_out_reg   <= 1'b0;
        baud_tick_reg <= 1'b0;
        os_tick_reg   <= 1'b0;
      end else begin
        if (bit_wrap) begin
          clk_out_reg <= ~clk_out_reg;
        end
        baud_tick_reg <= bit_wrap & ~clk_out_reg;
        os_tick_reg   <= os_wrap;
      end
    end
  end

  assign clk_out   = clk_out_reg;
  assign baud_tick = baud_tick_reg;
  assign os_tick   = os_tick_reg;

endmodule

// File: tb/tb_uart_clk_gen.sv
// Directed bench for uart_clk_gen: expected interval lengths (in clock
// cycles) are queued when stimulus is applied and popped as events occur.
module tb_uart_clk_gen;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_OS   = 2;

  logic       clk_50m  = 1'b0;
  logic       rst_n    = 1'b0;
  logic [2:0] baud_sel = 3'd0;
  logic       clk_out;
  logic       baud_tick;
  logic       os_tick;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];
  int n;

  uart_clk_gen dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .baud_sel  (baud_sel),
    .clk_out   (clk_out),
    .baud_tick (baud_tick),
    .os_tick   (os_tick)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check_val(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Pop the next expected interval and compare it with the measured one.
  task automatic score(input string tag, input int obs);
    int expv;
    if (exp_q.size() == 0) begin
      expv = -1;
    end else begin
      expv = exp_q.pop_front();
    end
    check_val(tag, obs, expv);
    $display("txn %-22s cycles=%0d expected=%0d", tag, obs, expv);
  endtask

  // Count falling edges until the event is seen or the budget runs out.
  task automatic wait_for(input int which, input int budget, output int cnt);
    logic prev;
    bit   hit;
    prev = clk_out;
    hit  = 1'b0;
    cnt  = 0;
    while (!hit && cnt < budget) begin
      @(negedge clk_50m);
      cnt++;
      case (which)
        EV_RISE: hit = (!prev && clk_out);
        EV_FALL: hit = (prev && !clk_out);
        default: hit = os_tick;
      endcase
      prev = clk_out;
    end
  endtask

  task automatic do_reset(input logic [2:0] sel);
    @(negedge clk_50m);
    rst_n    = 1'b0;
    baud_sel = sel;
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk_50m);
    check_val("reset_clk_out", clk_out, 0);
    check_val("reset_baud_tick", baud_tick, 0);
    check_val("reset_os_tick", os_tick, 0);

    // 9600: first rise, high time, low time, baud_tick alignment and width
    exp_q.push_back(2604);
    exp_q.push_back(2604);
    exp_q.push_back(2604);
    rst_n = 1'b1;
    wait_for(EV_RISE, 6000, n);
    score("first_rise_sel0", n);
    check_val("baud_tick_at_rise0", baud_tick, 1);
    wait_for(EV_FALL, 6000, n);
    score("high_time_sel0", n);
    check_val("baud_tick_at_fall", baud_tick, 0);
    wait_for(EV_RISE, 6000, n);
    score("low_time_sel0", n);
    check_val("baud_tick_at_rise1", baud_tick, 1);
    @(negedge clk_50m);
    check_val("baud_tick_width", baud_tick, 0);

    // 9600: oversample spacing from release
    do_reset(3'd0);
    exp_q.push_back(326);
    exp_q.push_back(326);
    wait_for(EV_OS, 1000, n);
    score("first_os_sel0", n);
    wait_for(EV_OS, 1000, n);
    score("os_spacing_sel0", n);

    // 115200 selected at run time: restart costs the clearing cycle
    exp_q.push_back(28);
    exp_q.push_back(27);
    exp_q.push_back(27);
    baud_sel = 3'd4;
    wait_for(EV_OS, 200, n);
    score("first_os_sel4", n);
    wait_for(EV_OS, 200, n);
    score("os_spacing_sel4_a", n);
    wait_for(EV_OS, 200, n);
    score("os_spacing_sel4_b", n);
    wait_for(EV_RISE, 1000, n);
    exp_q.push_back(217);
    exp_q.push_back(217);
    wait_for(EV_FALL, 1000, n);
    score("high_time_sel4", n);
    wait_for(EV_RISE, 1000, n);
    score("low_time_sel4", n);

    // Switch 0 -> 1 while clk_out is high
    do_reset(3'd0);
    exp_q.push_back(2604);
    wait_for(EV_RISE, 6000, n);
    score("rise_before_switch", n);
    repeat (100) @(negedge clk_50m);
    check_val("high_before_switch", clk_out, 1);
    baud_sel = 3'd1;
    @(negedge clk_50m);
    check_val("switch_clk_out", clk_out, 0);
    check_val("switch_baud_tick", baud_tick, 0);
    exp_q.push_back(1302);
    exp_q.push_back(1302);
    exp_q.push_back(1302);
    wait_for(EV_RISE, 3000, n);
    score("first_rise_sel1", n);
    wait_for(EV_FALL, 3000, n);
    score("high_time_sel1", n);
    wait_for(EV_RISE, 3000, n);
    score("low_time_sel1", n);

    // Out-of-table select 6 behaves as 9600
    baud_sel = 3'd6;
    exp_q.push_back(327);
    exp_q.push_back(326);
    exp_q.push_back(2605 - 327 - 326);
    exp_q.push_back(2604);
    exp_q.push_back(2604);
    wait_for(EV_OS, 1000, n);
    score("first_os_sel6", n);
    wait_for(EV_OS, 1000, n);
    score("os_spacing_sel6", n);
    wait_for(EV_RISE, 6000, n);
    score("first_rise_sel6", n);
    wait_for(EV_FALL, 6000, n);
    score("high_time_sel6", n);
    wait_for(EV_RISE, 6000, n);
    score("low_time_sel6", n);

    // Asynchronous reset while clk_out and baud_tick are high
    check_val("pre_reset_clk_out", clk_out, 1);
    check_val("pre_reset_baud_tick", baud_tick, 1);
    #5;
    rst_n    = 1'b0;
    baud_sel = 3'd0;
    #1;
    check_val("async_rst_clk_out", clk_out, 0);
    check_val("async_rst_baud_tick", baud_tick, 0);
    check_val("async_rst_os_tick", os_tick, 0);
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    exp_q.push_back(326);
    exp_q.push_back(2604 - 326);
    wait_for(EV_OS, 1000, n);
    score("first_os_after_rst", n);
    wait_for(EV_RISE, 6000, n);
    score("first_rise_after_rst", n);

    check_val("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
